// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and the datapath.
// Latency: none, plain wires; the controller drives every select and enable.
// Backpressure: none, the datapath consumes controls every cycle.
interface mc_ctrl_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       PCWrite;
  logic       Branch;
  logic       PCSrc;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  // controller side
  modport master (
    input  Op, Funct,
    output PCWrite, Branch, PCSrc, IorD, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, state_o
  );

  // datapath side
  modport slave (
    output Op, Funct,
    input  PCWrite, Branch, PCSrc, IorD, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Moore main controller of the multicycle MIPS core; emits all datapath selects/enables.
// Latency: outputs decoded from registered state; FETCH/MEMRD stretched MEM_LAT extra cycles.
// Backpressure: none; optional addi path enabled by defining MC_CTRL_ADDI_EN.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
`endif

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [1:0] r_wait;
  logic       w_wait_done;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;

  logic       w_pcwrite, w_branch, w_pcsrc, w_iord, w_memwrite, w_irwrite;
  logic       w_regdst, w_memtoreg, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_aluctl;

  // the memory wait is over once the counter has reached the configured latency
  assign w_wait_done = (r_wait == LAT);

  // state register and saturating wait counter, cleared whenever the state changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= 2'd0;
      else if (!w_wait_done)
        r_wait <= r_wait + 2'd1;
    end
  end

  // R-type function decode; unsupported codes fall back to add with no writeback
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 3'b010;
    case (bus.Funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  // next-state selection; unknown codes and unsupported opcodes return to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          6'b000000: w_next = S_EXEC;
          6'b100011,
          6'b101011: w_next = S_MEMADR;
          6'b000100: w_next = S_BEQ;
`ifdef MC_CTRL_ADDI_EN
          6'b001000: w_next = S_ADDIEX;
`endif
          default:   w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Op == 6'b100011)
          w_next = S_MEMRD;
        else if (bus.Op == 6'b101011)
          w_next = S_MEMWR;
        else
          w_next = S_FETCH;
      end
      S_MEMRD:  w_next = w_wait_done ? S_MEMWB : S_MEMRD;
      S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore output decode; everything not named for a state stays 0
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_pcsrc    = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluctl   = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_aluctl  = 3'b010;
        w_pcwrite = w_wait_done;
        w_irwrite = w_wait_done;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_aluctl  = 3'b010;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = 3'b010;
      end
      S_MEMRD:  w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluctl  = w_funct_alu;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = 1'b1;
        w_aluctl  = 3'b110;
        w_branch  = 1'b1;
        w_pcsrc   = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = 3'b010;
      end
      S_ADDIWB: w_regwrite = 1'b1;
`endif
      default: ;
    endcase
  end

  // enables are held low for the whole reset window so nothing fires on MEM_LAT=0
  assign bus.PCWrite    = w_pcwrite  & rst_n;
  assign bus.IRWrite    = w_irwrite  & rst_n;
  assign bus.MemWrite   = w_memwrite & rst_n;
  assign bus.RegWrite   = w_regwrite & rst_n;
  assign bus.Branch     = w_branch   & rst_n;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.IorD       = w_iord;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = w_aluctl;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle expected state/control words queued per instruction.
// Latency: one queue entry per clock cycle, compared mid-cycle.
// Backpressure: none; reset is also exercised in the middle of a load.
module tb_mc_ctrl_fsm;
  localparam int LAT = 1;

  logic clk;
  logic rst_n;
  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.MEM_LAT(LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
  } exp_t;

  exp_t  sb[$];
  int    checks;
  int    errors;
  string cur;

  // control word order: PCWrite Branch PCSrc IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUControl
  logic [14:0] obs_ctl;
  logic [4:0]  obs_en;
  assign obs_ctl = {bus.PCWrite, bus.Branch, bus.PCSrc, bus.IorD, bus.MemWrite, bus.IRWrite,
                    bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};
  assign obs_en  = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.Branch};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] cw(input logic pcw, input logic br, input logic pcs, input logic iord,
                                     input logic mw, input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [2:0] alu);
    return {pcw, br, pcs, iord, mw, irw, rd, m2r, rw, asa, asb, alu};
  endfunction

  task automatic push(input logic [3:0] st, input logic [14:0] ctl);
    exp_t e;
    e.st  = st;
    e.ctl = ctl;
    sb.push_back(e);
  endtask

  // expected cycle-by-cycle trace of one instruction, starting at its first FETCH cycle
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] alu;
    logic       ok;
    for (int i = 0; i < LAT; i++)
      push(4'd0, cw(0,0,0,0,0,0,0,0,0,0,2'b01,3'b010));
    push(4'd0, cw(1,0,0,0,0,1,0,0,0,0,2'b01,3'b010));
    push(4'd1, cw(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010));
    case (op)
      6'b100011: begin
        push(4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010));
        for (int i = 0; i <= LAT; i++)
          push(4'd3, cw(0,0,0,1,0,0,0,0,0,0,2'b00,3'b000));
        push(4'd4, cw(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000));
      end
      6'b101011: begin
        push(4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010));
        push(4'd5, cw(0,0,0,1,1,0,0,0,0,0,2'b00,3'b000));
      end
      6'b000000: begin
        ok = 1'b1;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default: begin alu = 3'b010; ok = 1'b0; end
        endcase
        push(4'd6, cw(0,0,0,0,0,0,0,0,0,1,2'b00,alu));
        if (ok) push(4'd7, cw(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000));
      end
      6'b000100: push(4'd8, cw(0,1,1,0,0,0,0,0,0,1,2'b00,3'b110));
`ifdef MC_CTRL_ADDI_EN
      6'b001000: begin
        push(4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010));
        push(4'd10, cw(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000));
      end
`endif
      default: ;
    endcase
  endtask

  // compare up to n queued cycles, one per clock, sampling mid-cycle
  task automatic consume(input int n);
    exp_t e;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      e = sb.pop_front();
      chk($sformatf("%s c%0d state", cur, i), 32'(bus.state_o), 32'(e.st));
      chk($sformatf("%s c%0d ctl", cur, i), 32'(obs_ctl), 32'(e.ctl));
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn);
    cur = name;
    bus.Op    = op;
    bus.Funct = fn;
    push_instr(op, fn);
    consume(sb.size());
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cur       = "init";
    rst_n     = 1'b0;
    bus.Op    = 6'd0;
    bus.Funct = 6'd0;
    #3;
    chk("reset state", 32'(bus.state_o), 32'd0);
    chk("reset enables", 32'(obs_en), 32'd0);
    chk("reset selects", 32'(obs_ctl), 32'(cw(0,0,0,0,0,0,0,0,0,0,2'b01,3'b010)));
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // load interrupted by reset in its second MEMRD cycle
    cur       = "lw_rst";
    bus.Op    = 6'b100011;
    bus.Funct = 6'd0;
    push_instr(6'b100011, 6'd0);
    consume(LAT + 4);
    chk("pre-reset in MEMRD", 32'(bus.state_o), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async reset state", 32'(bus.state_o), 32'd0);
    chk("async reset enables", 32'(obs_en), 32'd0);
    @(posedge clk);
    #1;
    chk("held reset state", 32'(bus.state_o), 32'd0);
    chk("held reset enables", 32'(obs_en), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run("lw",       6'b100011, 6'b000000);
    run("sw",       6'b101011, 6'b000000);
    run("sub",      6'b000000, 6'b100010);
    run("rbad",     6'b000000, 6'b000000);
    run("add",      6'b000000, 6'b100000);
    run("and",      6'b000000, 6'b100100);
    run("or",       6'b000000, 6'b100101);
    run("slt",      6'b000000, 6'b101010);
    run("beq",      6'b000100, 6'b000000);
    run("addi",     6'b001000, 6'b000000);
    run("j",        6'b000010, 6'b000000);
    run("lw2",      6'b100011, 6'b000000);

    // trailing FETCH cycle confirms the last instruction returned home
    cur = "tail";
    push(4'd0, cw(0,0,0,0,0,0,0,0,0,0,2'b01,3'b010));
    consume(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
